// File: rtl/mac_vec_engine_pkg.sv
// rtl/mac_vec_engine_pkg.sv - shared types, defaults and width helper for the MAC engine
package mac_vec_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_DW = 4;
  localparam int DEF_N  = 10;

  // Smallest w with 2**w >= value; usable in parameter expressions
  function automatic int clog2_f(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mac_vec_engine_if.sv
// rtl/mac_vec_engine_if.sv - operand pair handshake bundle
interface mac_vec_engine_if #(
  parameter int DW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;

  modport master (output in_valid, output a, output b, input in_ready);
  modport slave  (input in_valid, input a, input b, output in_ready);
endinterface

// File: rtl/mac_vec_engine_mult_stage.sv
// rtl/mac_vec_engine_mult_stage.sv - registered DW x DW multiplier, signed/unsigned select
module mac_vec_engine_mult_stage #(
  parameter int DW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            signed_mode_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic [2*DW-1:0] prod_o,
  output logic            valid_o
);

  logic [2*DW-1:0] ext_a;
  logic [2*DW-1:0] ext_b;
  logic [2*DW-1:0] prod_d;
  logic [2*DW-1:0] prod_q;
  logic            valid_q;

  // Extend operands to full product width so one multiply serves both modes
  always_comb begin
    ext_a  = signed_mode_i ? {{DW{a_i[DW-1]}}, a_i} : {{DW{1'b0}}, a_i};
    ext_b  = signed_mode_i ? {{DW{b_i[DW-1]}}, b_i} : {{DW{1'b0}}, b_i};
    prod_d = ext_a * ext_b;
  end

  // Product register with its valid bit; product only captured on accepted pairs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        prod_q <= prod_d;
      end
    end
  end

  assign prod_o  = prod_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mac_vec_engine.sv
// rtl/mac_vec_engine.sv - pipelined dot-product engine with saturation and overflow flag
module mac_vec_engine
  import mac_vec_engine_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int N     = DEF_N,
  parameter int ACC_W = 2 * DW + clog2_f(N),
  parameter int SAT   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_mode_i,
  mac_vec_engine_if.slave  in_if,
  output logic [ACC_W-1:0] out_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int PW = 2 * DW;
  localparam int CW = clog2_f(N + 1);
  // Sum width leaves headroom above both the accumulator and the product
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 2;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;

  logic             in_ready;
  logic             accept;
  logic [PW-1:0]    prod;
  logic             prod_valid;

  logic [SW-1:0]    acc_ext;
  logic [SW-1:0]    prod_ext;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    max_v;
  logic [SW-1:0]    min_v;
  logic             over_hi;
  logic             over_lo;
  logic [ACC_W-1:0] acc_next;

  assign in_ready       = (state_q == ST_RUN) && (count_q < CW'(N));
  assign accept         = in_ready && in_if.in_valid;
  assign in_if.in_ready = in_ready;

  mac_vec_engine_mult_stage #(.DW(DW)) u_mult (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (accept),
    .signed_mode_i (mode_q),
    .a_i           (in_if.a),
    .b_i           (in_if.b),
    .prod_o        (prod),
    .valid_o       (prod_valid)
  );

  // Guarded accumulate, range check against the ACC_W window, optional clamp
  always_comb begin
    acc_ext  = mode_q ? {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q} : {{(SW-ACC_W){1'b0}}, acc_q};
    prod_ext = mode_q ? {{(SW-PW){prod[PW-1]}}, prod} : {{(SW-PW){1'b0}}, prod};
    sum      = acc_ext + prod_ext;
    if (mode_q) begin
      max_v = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
      min_v = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    end else begin
      max_v = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
      min_v = '0;
    end
    over_hi  = $signed(sum) > $signed(max_v);
    over_lo  = $signed(sum) < $signed(min_v);
    acc_next = sum[ACC_W-1:0];
    if ((SAT != 0) && over_hi) begin
      acc_next = max_v[ACC_W-1:0];
    end else if ((SAT != 0) && over_lo) begin
      acc_next = min_v[ACC_W-1:0];
    end
  end

  // FSM next state plus job-level register updates
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    out_d   = out_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          count_d = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          mode_d  = signed_mode_i;
        end
      end
      ST_RUN: begin
        if (accept) begin
          count_d = count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        out_d   = acc_q;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Products only arrive in RUN/DRAIN, never alongside the IDLE clear
    if (prod_valid) begin
      acc_d = acc_next;
      ovf_d = ovf_q | over_hi | over_lo;
    end
  end

  // State and datapath registers; reset discards any in-flight job
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
    end
  end

  assign out_o      = out_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_mac_vec_engine.sv
// tb/tb_mac_vec_engine.sv - scoreboard bench for mac_vec_engine at three configurations
module tb_mac_vec_engine;

  localparam int DW = 4;
  localparam int N  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_mode;
  logic          in_valid;
  logic [DW-1:0] a;
  logic [DW-1:0] b;

  logic [11:0] out_def;
  logic [9:0]  out_sat;
  logic [9:0]  out_wrap;
  logic        done_def, done_sat, done_wrap;
  logic        busy_def, busy_sat, busy_wrap;
  logic        ovf_def, ovf_sat, ovf_wrap;

  mac_vec_engine_if #(.DW(DW)) if_def ();
  mac_vec_engine_if #(.DW(DW)) if_sat ();
  mac_vec_engine_if #(.DW(DW)) if_wrap ();

  assign if_def.in_valid  = in_valid;
  assign if_def.a         = a;
  assign if_def.b         = b;
  assign if_sat.in_valid  = in_valid;
  assign if_sat.a         = a;
  assign if_sat.b         = b;
  assign if_wrap.in_valid = in_valid;
  assign if_wrap.a        = a;
  assign if_wrap.b        = b;

  always #5 clk = ~clk;

  mac_vec_engine #(.DW(DW), .N(N)) u_def (
    .clk_i(clk), .rst_i(rst), .start_i(start), .signed_mode_i(signed_mode),
    .in_if(if_def), .out_o(out_def), .done_o(done_def), .busy_o(busy_def), .overflow_o(ovf_def)
  );

  mac_vec_engine #(.DW(DW), .N(N), .ACC_W(10), .SAT(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .signed_mode_i(signed_mode),
    .in_if(if_sat), .out_o(out_sat), .done_o(done_sat), .busy_o(busy_sat), .overflow_o(ovf_sat)
  );

  mac_vec_engine #(.DW(DW), .N(N), .ACC_W(10), .SAT(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .signed_mode_i(signed_mode),
    .in_if(if_wrap), .out_o(out_wrap), .done_o(done_wrap), .busy_o(busy_wrap), .overflow_o(ovf_wrap)
  );

  typedef struct {
    longint e_def;
    bit     o_def;
    longint e_sat;
    bit     o_sat;
    longint e_wrap;
    bit     o_wrap;
  } exp_t;

  exp_t sb[$];
  int   job_a[$];
  int   job_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  bit   prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Step-by-step reference: true sum, range test, clamp or wrap per step
  function automatic longint ref_dot(input bit sm, input int acc_w, input bit sat, output bit ovf);
    longint acc, mx, mn, mask, x, y;
    acc  = 0;
    ovf  = 1'b0;
    mask = (longint'(1) << acc_w) - 1;
    mx   = sm ? (longint'(1) << (acc_w - 1)) - 1 : mask;
    mn   = sm ? -(longint'(1) << (acc_w - 1)) : 0;
    for (int i = 0; i < job_a.size(); i++) begin
      x = job_a[i] & 15;
      y = job_b[i] & 15;
      if (sm && x >= 8) x = x - 16;
      if (sm && y >= 8) y = y - 16;
      acc = acc + x * y;
      if (acc > mx || acc < mn) begin
        ovf = 1'b1;
        if (sat) acc = (acc > mx) ? mx : mn;
        else begin
          acc = acc & mask;
          if (acc > mx) acc = acc - (longint'(1) << acc_w);
        end
      end
    end
    return acc & mask;
  endfunction

  task automatic load(input int av, input int bv);
    job_a.delete();
    job_b.delete();
    for (int i = 0; i < N; i++) begin
      job_a.push_back(av);
      job_b.push_back(bv);
    end
  endtask

  task automatic push_job(input bit sm);
    exp_t e;
    bit   o;
    e.e_def  = ref_dot(sm, 12, 1'b1, o); e.o_def  = o;
    e.e_sat  = ref_dot(sm, 10, 1'b1, o); e.o_sat  = o;
    e.e_wrap = ref_dot(sm, 10, 1'b0, o); e.o_wrap = o;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((busy_def || sb.size() != 0) && guard < 200);
    if (guard >= 200) check("idle_timeout", 0, 1);
  endtask

  task automatic start_job(input bit sm);
    wait_idle();
    start       = 1'b1;
    signed_mode = sm;
    push_job(sm);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy_def, 1);
  endtask

  // pattern 0: back-to-back; pattern 1: valid on every third cycle
  task automatic feed(input int pattern, input int n_lim);
    int idx, step, guard;
    idx = 0; step = 0; guard = 0;
    while (idx < n_lim && guard < 500) begin
      @(negedge clk);
      in_valid = (pattern == 0) || (step % 3 == 0);
      a = DW'(job_a[idx]);
      b = DW'(job_b[idx]);
      step++;
      guard++;
      check("in_ready_run", if_def.in_ready, 1);
      if (in_valid && if_def.in_ready) begin
        last_acc = cyc + 1;
        idx++;
      end
    end
    if (guard >= 500) check("feed_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (n_lim == N) check("in_ready_drop", if_def.in_ready, 0);
  endtask

  // Result monitor: pops the scoreboard on each done pulse
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done_def) begin
        check("done_width", prev_done, 0);
        check("done_latency", cyc, last_acc + 2);
        check("done_lockstep", {done_sat, done_wrap}, 2'b11);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_def", out_def, e.e_def);
          check("ovf_def", ovf_def, e.o_def);
          check("out_sat", out_sat, e.e_sat);
          check("ovf_sat", ovf_sat, e.o_sat);
          check("out_wrap", out_wrap, e.e_wrap);
          check("ovf_wrap", ovf_wrap, e.o_wrap);
        end
      end
      prev_done = done_def;
    end
  end

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_out", out_def, 0);
    check("rst_busy", busy_def, 0);
    check("rst_done", done_def, 0);
    check("rst_ovf", ovf_def, 0);
    check("rst_ready", if_def.in_ready, 0);
    rst = 1'b0;

    // Unsigned max operands; narrow instances saturate / wrap
    load(15, 15); start_job(1'b0); feed(0, N); wait_idle();
    check("t1_const", out_def, 2250);
    check("t1_sat_const", out_sat, 1023);
    check("t1_wrap_const", out_wrap, 202);

    // Signed jobs
    load(-8, 7); start_job(1'b1); feed(0, N); wait_idle();
    check("t2a_const", out_def, 12'hDD0);
    load(-8, -8); start_job(1'b1); feed(0, N); wait_idle();
    check("t2b_const", out_def, 640);
    check("t2b_ovf_def", ovf_def, 0);

    // Back-pressure on in_valid
    load(3, 3); start_job(1'b0); feed(1, N); wait_idle();
    check("t4_const", out_def, 90);

    // Reset after five accepts: job discarded, no done
    load(7, 7); start_job(1'b0); feed(0, 5);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out", out_def, 0);
    check("mid_rst_busy", busy_def, 0);
    check("mid_rst_done", done_def, 0);
    check("mid_rst_ready", if_def.in_ready, 0);
    check("mid_rst_out_sat", out_sat, 0);
    repeat (20) @(negedge clk);
    load(2, 2); start_job(1'b0); feed(0, N); wait_idle();
    check("t5_const", out_def, 40);

    // start pulse while busy is ignored
    load(3, 3); start_job(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    feed(1, N); wait_idle();
    check("t6a_const", out_def, 90);

    // start held through DONE: exactly one follow-on job, begun after done
    load(3, 3); wait_idle();
    start = 1'b1; signed_mode = 1'b0;
    push_job(1'b0);
    feed(0, N);
    guard = 0;
    while (!done_def && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("held_done_seen", done_def, 1);
    check("held_idle_at_done", busy_def, 0);
    load(5, 1); push_job(1'b0);
    @(negedge clk);
    start = 1'b0;
    check("held_busy", busy_def, 1);
    feed(0, N); wait_idle();
    check("t6b_const", out_def, 50);
    repeat (5) @(negedge clk);
    check("held_single_job", busy_def, 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
